// File: rtl/dwt_haar_ml.sv
// Frame-based multi-level reversible Haar DWT using integer lifting.
// Loads NUMEL samples, runs up to LEVELS in-place passes over two RAM banks, then dumps in Mallat order.
module dwt_haar_ml #(
  parameter int WIDTH  = 16,
  parameter int NUMEL  = 512,
  parameter int LEVELS = 3,
  parameter int OWIDTH = WIDTH + LEVELS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid_i,
  input  logic signed [WIDTH-1:0]           din,
  input  logic [$clog2(LEVELS+1)-1:0]       levels_i,
  output logic                              ready_o,
  output logic                              drop_o,
  output logic                              valid_o,
  output logic signed [OWIDTH-1:0]          dout,
  output logic                              last_o
);

  localparam int AW = $clog2(NUMEL);
  localparam int LW = $clog2(LEVELS + 1);

  typedef enum logic [1:0] {LOAD, CALC, DUMP} state_t;

  state_t                   state;
  logic [AW-1:0]            idx;
  logic [LW-1:0]            lvl_q;
  logic [LW-1:0]            lvl_cnt;
  logic [AW:0]              rc;
  logic signed [OWIDTH-1:0] e_q;
  logic signed [OWIDTH-1:0] d_q;
  logic [AW-1:0]            dwa_q;
  logic                     sel_q;

  logic signed [OWIDTH-1:0] bank0 [NUMEL];
  logic signed [OWIDTH-1:0] bank1 [NUMEL];
  logic signed [OWIDTH-1:0] rd0, rd1;

  logic [AW:0]              n_cur;
  logic [LW-1:0]            lvl_in;
  logic                     accept, is_pair, is_dwr, is_ecap, lvl_done;
  logic [AW-1:0]            raddr, waddr;
  logic signed [OWIDTH-1:0] wdata, rd_src, d_w, s_w;
  logic                     we0, we1;

  // Details of level l stay only in bank l%2, so the dump picks the bank by address region.
  function automatic logic dump_sel(input logic [AW-1:0] a, input logic [LW-1:0] lv);
    logic s;
    s = lv[0];
    for (int l = LEVELS; l >= 1; l--)
      if (l <= int'(lv) && int'(a) >= (NUMEL >> l)) s = (l % 2) == 1;
    return s;
  endfunction

  assign lvl_in   = (int'(levels_i) > LEVELS) ? LW'(LEVELS) : levels_i;
  assign n_cur    = (AW+1)'(NUMEL) >> (lvl_cnt - LW'(1));
  assign rd_src   = lvl_cnt[0] ? rd0 : rd1;
  assign d_w      = rd_src - e_q;
  assign s_w      = e_q + (d_w >>> 1);
  assign accept   = (state == LOAD) && valid_i && ready_o;
  assign is_pair  = (state == CALC) && !rc[0] && rc >= (AW+1)'(2) && rc <= n_cur;
  assign is_dwr   = (state == CALC) && rc[0] && rc >= (AW+1)'(3);
  assign is_ecap  = (state == CALC) && rc[0] && rc < n_cur;
  assign lvl_done = (state == CALC) && rc == n_cur + (AW+1)'(1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    raddr = '0;
    case (state)
      CALC:    if (rc < n_cur) raddr = rc[AW-1:0];
      DUMP:    raddr = idx + AW'(1);
      default: raddr = '0;
    endcase
  end

  // Each pair writes s on the even cycle and d on the following odd cycle: one write port per bank.
  always_comb begin
    we0   = 1'b0;
    we1   = 1'b0;
    waddr = '0;
    wdata = '0;
    if (accept) begin
      we0   = 1'b1;
      waddr = idx;
      wdata = OWIDTH'(din);
    end else if (is_pair || is_dwr) begin
      we0 = !lvl_cnt[0];
      we1 = lvl_cnt[0];
      if (is_pair) begin
        waddr = AW'((rc >> 1) - (AW+1)'(1));
        wdata = s_w;
      end else begin
        waddr = dwa_q;
        wdata = d_q;
      end
    end
  end

  // NOTE: RAM banks carry no reset; their contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we0) bank0[waddr] <= wdata;
    if (we1) bank1[waddr] <= wdata;
    rd0 <= bank0[raddr];
    rd1 <= bank1[raddr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= LOAD;
      idx     <= '0;
      lvl_q   <= '0;
      lvl_cnt <= '0;
      rc      <= '0;
      e_q     <= '0;
      d_q     <= '0;
      dwa_q   <= '0;
      sel_q   <= 1'b0;
      ready_o <= 1'b1;
      drop_o  <= 1'b0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      drop_o <= valid_i && !ready_o;
      sel_q  <= dump_sel(raddr, lvl_q);
      if (is_ecap) e_q <= rd_src;
      if (is_pair) begin
        d_q   <= d_w;
        dwa_q <= AW'((n_cur >> 1) + (rc >> 1) - (AW+1)'(1));
      end
      case (state)
        LOAD: if (accept) begin
          if (idx == '0) lvl_q <= lvl_in;
          idx <= idx + AW'(1);
          if (idx == AW'(NUMEL - 1)) begin
            ready_o <= 1'b0;
            if (lvl_q != '0) begin
              state   <= CALC;
              lvl_cnt <= LW'(1);
              rc      <= '0;
            end else begin
              state   <= DUMP;
              valid_o <= 1'b1;
            end
          end
        end
        CALC: begin
          if (lvl_done) begin
            rc <= '0;
            if (lvl_cnt == lvl_q) begin
              state   <= DUMP;
              valid_o <= 1'b1;
            end else begin
              lvl_cnt <= lvl_cnt + LW'(1);
            end
          end else begin
            rc <= rc + (AW+1)'(1);
          end
        end
        DUMP: begin
          idx    <= idx + AW'(1);
          last_o <= (idx == AW'(NUMEL - 2));
          if (idx == AW'(NUMEL - 1)) begin
            state   <= LOAD;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            ready_o <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign dout = valid_o ? (sel_q ? rd1 : rd0) : '0;

endmodule
